uart_rx_core: RTL

//   UART receiver, the receive-side counterpart of the UART_TX path. Oversamples RX_IN,

---
 rtl/uart_rx_core_if.sv | 24 ++
 rtl/uart_rx_core.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_core_if.sv
// Bundles the UART receiver's serial input, frame configuration and word-delivery outputs.
// The master side drives the line and configuration; the slave is the receiver.
interface uart_rx_core_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rx_in;
  logic                  par_en;
  logic                  par_typ;
  logic [5:0]            prescale;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  modport master (
    output rx_in, par_en, par_typ, prescale,
    input  p_data, data_valid, par_err, stp_err
  );

  modport slave (
    input  rx_in, par_en, par_typ, prescale,
    output p_data, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: majority-voted bits, LSB-first, optional parity and a stop check.
// Frames are resolved at the end of the stop bit into registered 1-cycle pulses.
module uart_rx_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  uart_rx_core_if.slave  bus
);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                state_q, state_d;
  logic                  rx_meta_q, rx_s_q;
  logic                  par_en_q, par_typ_q;
  logic [5:0]            presc_q;
  logic [5:0]            edge_cnt_q, edge_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [1:0]            samp_q, samp_d;
  logic                  par_fail_q, par_fail_d;
  logic                  stop_q, stop_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  dv_q, dv_d, pe_q, pe_d, se_q, se_d;

  logic [5:0] half;
  logic       last_edge, s_lo, s_mid, s_hi, bit_val, exp_par, last_bit;

  assign half      = {1'b0, presc_q[5:1]};
  assign last_edge = (edge_cnt_q == presc_q - 6'd1);
  assign s_lo      = (edge_cnt_q == half - 6'd1);
  assign s_mid     = (edge_cnt_q == half);
  assign s_hi      = (edge_cnt_q == half + 6'd1);
  // Third vote is the live synchronised sample taken at s_hi.
  assign bit_val   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
  assign exp_par   = par_typ_q ? ~^shift_q : ^shift_q;
  assign last_bit  = (bit_cnt_q == BW'(DATA_WIDTH - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!rx_s_q) state_d = S_START;
      S_START: begin
        if (s_hi && bit_val)  state_d = S_IDLE;
        else if (last_edge)   state_d = S_DATA;
      end
      S_DATA:   if (last_edge && last_bit) state_d = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: if (last_edge) state_d = S_STOP;
      S_STOP:   if (last_edge) state_d = rx_s_q ? S_IDLE : S_START;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    samp_d     = samp_q;
    par_fail_d = par_fail_q;
    stop_d     = stop_q;
    p_data_d   = p_data_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;
    if (state_q == S_IDLE) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else begin
      edge_cnt_d = last_edge ? 6'd0 : edge_cnt_q + 6'd1;
      if (s_lo)  samp_d[0] = rx_s_q;
      if (s_mid) samp_d[1] = rx_s_q;
      case (state_q)
        S_DATA: begin
          if (s_hi) shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
          if (last_edge) bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
        end
        S_PARITY: if (s_hi && (bit_val != exp_par)) par_fail_d = 1'b1;
        S_STOP: begin
          if (s_hi) stop_d = bit_val;
          if (last_edge) begin
            se_d = ~stop_q;
            pe_d = par_fail_q;
            if (stop_q && !par_fail_q) begin
              p_data_d = shift_q;
              dv_d     = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    if (state_d == S_START && state_q != S_START) par_fail_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      presc_q    <= '0;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      samp_q     <= '0;
      par_fail_q <= 1'b0;
      stop_q     <= 1'b0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      rx_meta_q  <= bus.rx_in;
      rx_s_q     <= rx_meta_q;
      // Configuration is frozen for the whole frame once the start edge is seen.
      if (state_q == S_IDLE && !rx_s_q) begin
        par_en_q  <= bus.par_en;
        par_typ_q <= bus.par_typ;
        presc_q   <= bus.prescale;
      end
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      samp_q     <= samp_d;
      par_fail_q <= par_fail_d;
      stop_q     <= stop_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end

  assign bus.p_data     = p_data_q;
  assign bus.data_valid = dv_q;
  assign bus.par_err    = pe_q;
  assign bus.stp_err    = se_q;
endmodule
